// File: rtl/fixed_p_std_div_seq.sv
//======================================================================
// Module  : fixed_p_std_div_seq
// Brief   : Sequential radix-2 restoring unsigned fixed-point divider,
//           out = (left << FRACT_WIDTH) / right, go/done handshake,
//           saturation + overflow/div-by-zero flags, remainder output.
//           Macro FIXED_P_DIV_ROUND_EN: extra guard iteration, round half up.
// Revision: 1.0
//======================================================================
`default_nettype none

module fixed_p_std_div_seq #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             done
);

`ifdef FIXED_P_DIV_ROUND_EN
  localparam int ITERS = WIDTH + FRACT_WIDTH + 1;
`else
  localparam int ITERS = WIDTH + FRACT_WIDTH;
`endif
  localparam int               CNT_W     = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  generate
    if (INT_WIDTH + FRACT_WIDTH != WIDTH || WIDTH < 2 || FRACT_WIDTH < 1) begin : g_param_check
      $error("fixed_p_std_div_seq: need INT_WIDTH+FRACT_WIDTH==WIDTH, WIDTH>=2, FRACT_WIDTH>=1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             ovf;
  logic [CNT_W-1:0] count;

  logic             div_zero;
  logic             last_iter;
  logic [WIDTH:0]   rem_shift;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             ovf_next;
  logic [WIDTH-1:0] quo_final;
  logic             ovf_final;
`ifdef FIXED_P_DIV_ROUND_EN
  logic [WIDTH:0]   quo_round;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (go) state_next = S_BUSY;
      S_BUSY:  if (div_zero || last_iter) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The dividend register shifts in zeros, which supplies the FRACT_WIDTH
  // zero-extension bits once the operand bits are exhausted.
  always_comb begin
    div_zero  = (divisor == '0);
    last_iter = (count == LAST_ITER);
    rem_shift = {rem, dividend[WIDTH-1]};
    qbit      = (rem_shift >= {1'b0, divisor});
    rem_next  = qbit ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], qbit};
    ovf_next  = ovf | quo[WIDTH-1];
`ifdef FIXED_P_DIV_ROUND_EN
    // Final iteration yields the guard bit; it is added rather than shifted in.
    quo_round = {1'b0, quo} + {{WIDTH{1'b0}}, qbit};
    quo_final = quo_round[WIDTH-1:0];
    ovf_final = ovf | quo_round[WIDTH];
`else
    quo_final = quo_next;
    ovf_final = ovf_next;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend      <= '0;
      divisor       <= '0;
      rem           <= '0;
      quo           <= '0;
      ovf           <= 1'b0;
      count         <= '0;
      out           <= '0;
      out_remainder <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            dividend <= left;
            divisor  <= right;
            rem      <= '0;
            quo      <= '0;
            ovf      <= 1'b0;
            count    <= '0;
          end
        end
        S_BUSY: begin
          if (div_zero) begin
            // Dividend is left untouched here, so it still holds the operand.
            out           <= '1;
            out_remainder <= dividend;
            div_by_zero   <= 1'b1;
            overflow      <= 1'b0;
            done          <= 1'b1;
          end else begin
            dividend <= dividend << 1;
            rem      <= rem_next;
            count    <= count + CNT_W'(1);
`ifdef FIXED_P_DIV_ROUND_EN
            if (!last_iter) begin
              quo <= quo_next;
              ovf <= ovf_next;
            end
`else
            quo <= quo_next;
            ovf <= ovf_next;
`endif
            if (last_iter) begin
              out           <= ovf_final ? '1 : quo_final;
              out_remainder <= rem_next;
              div_by_zero   <= 1'b0;
              overflow      <= ovf_final;
              done          <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_p_std_div_seq.sv
//======================================================================
// Module  : tb_fixed_p_std_div_seq
// Brief   : Self-checking bench for fixed_p_std_div_seq (8-bit Q4.4).
// Revision: 1.0
//======================================================================
`default_nettype none

module tb_fixed_p_std_div_seq;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int FW = 4;
  localparam int N  = W + FW;
`ifdef FIXED_P_DIV_ROUND_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif
  localparam int PER = LAT + 1;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         go    = 1'b0;
  logic [W-1:0] left  = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] out;
  logic [W-1:0] out_remainder;
  logic         div_by_zero;
  logic         overflow;
  logic         done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  fixed_p_std_div_seq #(
    .WIDTH      (W),
    .INT_WIDTH  (IW),
    .FRACT_WIDTH(FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .left         (left),
    .right        (right),
    .out          (out),
    .out_remainder(out_remainder),
    .div_by_zero  (div_by_zero),
    .overflow     (overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: scaled integer division, then saturation.
  function automatic void model_calc(input logic [W-1:0] l, input logic [W-1:0] r,
                                     output logic [W-1:0] o, output logic [W-1:0] rm,
                                     output logic dz, output logic ov, output int lat);
    longint scaled, q, rr;
    if (r == 0) begin
      o = '1; rm = l; dz = 1'b1; ov = 1'b0; lat = 2;
    end else begin
      scaled = longint'(l) << FW;
      q  = scaled / longint'(r);
      rr = scaled % longint'(r);
`ifdef FIXED_P_DIV_ROUND_EN
      if (2 * rr >= longint'(r)) begin
        q  = q + 1;
        rr = 2 * rr - longint'(r);
      end else begin
        rr = 2 * rr;
      end
`endif
      lat = LAT;
      ov  = (q > longint'((1 << W) - 1));
      o   = ov ? '1 : W'(q);
      rm  = W'(rr);
      dz  = 1'b0;
    end
  endfunction

  // Timing model: a request is accepted when idle, results appear
  // lat cycles later for exactly one cycle, then one dead cycle.
  logic [W-1:0] m_out, m_rem, p_out, p_rem;
  logic         m_dz, m_ov, m_done, p_dz, p_ov;
  int           m_wait, p_lat;
  bit           m_cool;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = '0; m_rem = '0; m_dz = 1'b0; m_ov = 1'b0; m_done = 1'b0;
      m_wait = 0; m_cool = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_wait > 0) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_out = p_out; m_rem = p_rem; m_dz = p_dz; m_ov = p_ov;
          m_done = 1'b1; m_cool = 1'b1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (go) begin
        model_calc(left, right, p_out, p_rem, p_dz, p_ov, p_lat);
        m_wait = p_lat - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_done", done, m_done);
      chk("cyc_out", out, m_out);
      chk("cyc_rem", out_remainder, m_rem);
      chk("cyc_dbz", div_by_zero, m_dz);
      chk("cyc_ovf", overflow, m_ov);
    end
  end

  // Called just after a rising edge of an idle cycle; returns likewise.
  task automatic run_op(input logic [W-1:0] l, input logic [W-1:0] r, input int e_lat,
                        input logic [W-1:0] e_out, input logic [W-1:0] e_rem,
                        input logic e_dz, input logic e_ov, input string nm);
    int k;
    bit seen;
    left = l; right = r; go = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      go = 1'b0;
      k++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({nm, "_lat"}, k, e_lat);
    chk({nm, "_out"}, out, e_out);
    chk({nm, "_rem"}, out_remainder, e_rem);
    chk({nm, "_dbz"}, div_by_zero, e_dz);
    chk({nm, "_ovf"}, overflow, e_ov);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] tl [5] = '{8'h01, 8'hFF, 8'h07, 8'hFF, 8'h00};
  logic [W-1:0] tr [5] = '{8'h03, 8'hFF, 8'h10, 8'h0F, 8'h05};

  initial begin
    logic [W-1:0] eo, er;
    logic         ed, ev;
    int           el, k, npulse, ndone;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_rem", out_remainder, 8'h00);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(8'h30, 8'h20, LAT, 8'h18, 8'h00, 1'b0, 1'b0, "t1");
`ifdef FIXED_P_DIV_ROUND_EN
    run_op(8'h20, 8'h30, LAT, 8'h0B, 8'h10, 1'b0, 1'b0, "t2");
`else
    run_op(8'h20, 8'h30, LAT, 8'h0A, 8'h20, 1'b0, 1'b0, "t2");
`endif
    run_op(8'h10, 8'h00, 2, 8'hFF, 8'h10, 1'b1, 1'b0, "t3");
    run_op(8'hFF, 8'h10, LAT, 8'hFF, 8'h00, 1'b0, 1'b0, "t_maxq");

    for (int i = 0; i < 5; i++) begin
      model_calc(tl[i], tr[i], eo, er, ed, ev, el);
      run_op(tl[i], tr[i], el, eo, er, ed, ev, "tbl");
    end

    run_op(8'hF0, 8'h01, LAT, 8'hFF, 8'h00, 1'b0, 1'b1, "t4");

    // Abort with reset mid-operation.
    left = 8'h30; right = 8'h20; go = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      go = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("t5_out", out, 8'h00);
    chk("t5_rem", out_remainder, 8'h00);
    chk("t5_dbz", div_by_zero, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    @(posedge clk); #1;
    run_op(8'h30, 8'h20, LAT, 8'h18, 8'h00, 1'b0, 1'b0, "t5_rerun");

    // go held high; operands disturbed while busy.
    left = 8'h30; right = 8'h20; go = 1'b1;
    k = 0; npulse = 0;
    while (npulse < 3 && k < 80) begin
      @(posedge clk); #1;
      k++;
      if (k % PER == 3) begin left = 8'hAA; right = 8'h00; end
      if (k % PER == 10) begin left = 8'h30; right = 8'h20; end
      @(negedge clk);
      if (done) begin
        chk("t6_cycle", k, LAT + npulse * PER);
        chk("t6_out", out, 8'h18);
        chk("t6_rem", out_remainder, 8'h00);
        npulse++;
      end
    end
    chk("t6_pulses", npulse, 3);
    @(posedge clk); #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
